// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared widths, instruction field positions, opcode constants,
//                class / FSM enumerations and the combinational decode helper
//                for the instruction decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int INSTR_W  = 41;
    localparam int PC_W     = 17;
    localparam int OPC_W    = 9;
    localparam int OPND_W   = 16;
    localparam int CLASS_W  = 3;
    localparam int ALUOP_W  = 6;
    localparam int ENTRY_W  = PC_W + INSTR_W;

    // Instruction word field positions
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 8;
    localparam int OPA_LSB  = 9;
    localparam int OPA_MSB  = 24;
    localparam int OPB_LSB  = 25;
    localparam int OPB_MSB  = 40;

    // Opcode constants
    localparam logic [OPC_W-1:0] OPC_NOP    = 9'h000;
    localparam logic [OPC_W-1:0] OPC_ALU_LO = 9'h001;
    localparam logic [OPC_W-1:0] OPC_ALU_HI = 9'h03F;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 9'h040;
    localparam logic [OPC_W-1:0] OPC_STORE  = 9'h041;
    localparam logic [OPC_W-1:0] OPC_JUMP   = 9'h080;
    localparam logic [OPC_W-1:0] OPC_BRZ    = 9'h081;
    localparam logic [OPC_W-1:0] OPC_HALT   = 9'h1FF;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_BRZ     = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } class_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        class_e              cls;
        logic [ALUOP_W-1:0]  alu_op;
        logic [OPND_W-1:0]   opa;
        logic [OPND_W-1:0]   opb;
        logic                illegal;
    } bundle_t;

    // Pure decode of one instruction word into its output bundle fields.
    function automatic bundle_t decode_instr(input logic [INSTR_W-1:0] instr);
        bundle_t           b;
        logic [OPC_W-1:0]  opc;
        opc       = instr[OPC_MSB:OPC_LSB];
        b.cls     = CLS_ILLEGAL;
        b.alu_op  = '0;
        b.opa     = instr[OPA_MSB:OPA_LSB];
        b.opb     = instr[OPB_MSB:OPB_LSB];
        b.illegal = 1'b0;
        if (opc == OPC_NOP) begin
            b.cls = CLS_NOP;
        end else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) begin
            b.cls    = CLS_ALU;
            b.alu_op = opc[ALUOP_W-1:0];
        end else if (opc == OPC_LOAD) begin
            b.cls = CLS_LOAD;
        end else if (opc == OPC_STORE) begin
            b.cls = CLS_STORE;
        end else if (opc == OPC_JUMP) begin
            b.cls = CLS_JUMP;
        end else if (opc == OPC_BRZ) begin
            b.cls = CLS_BRZ;
        end else if (opc == OPC_HALT) begin
            b.cls = CLS_HALT;
        end else begin
            // Undefined opcodes carry no operands downstream
            b.cls     = CLS_ILLEGAL;
            b.illegal = 1'b1;
            b.opa     = '0;
            b.opb     = '0;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : decode_fifo
//  Description : Small synchronous FIFO buffering fetched {pc, instr} entries
//                ahead of the decode output register. Head entry is presented
//                combinationally on o_rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 58
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_ADDR_W:0]   r_count;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + c_ADDR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + c_ADDR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (i_push && !rst && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : Pipeline decode stage: buffers fetched instructions, decodes
//                them into a registered output bundle with valid/ready
//                handshake, and stalls in a HALT state after issuing a HALT
//                instruction until resume. flush discards all pending work.
//                Optional macro DECODE_STATS_EN adds saturating handshake
//                counters stat_decoded / stat_illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    input  logic                resume,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [CLASS_W-1:0]  out_class,
    output logic [ALUOP_W-1:0]  out_alu_op,
    output logic [OPND_W-1:0]   out_opa,
    output logic [OPND_W-1:0]   out_opb,
    output logic                out_illegal,
    output logic                halted
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]         stat_decoded,
    output logic [15:0]         stat_illegal
`endif
);

    state_e              r_state;
    state_e              w_state_next;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ENTRY_W-1:0]  w_fifo_rdata;
    logic                w_push;
    logic                w_load;
    logic                w_out_fire;

    logic [PC_W-1:0]     w_head_pc;
    logic [INSTR_W-1:0]  w_head_instr;
    bundle_t             w_head_dec;

    logic                r_out_valid;
    logic [PC_W-1:0]     r_out_pc;
    logic [CLASS_W-1:0]  r_out_class;
    logic [ALUOP_W-1:0]  r_out_alu_op;
    logic [OPND_W-1:0]   r_out_opa;
    logic [OPND_W-1:0]   r_out_opb;
    logic                r_out_illegal;

    // Input side depends only on local state and flush, never on out_ready
    assign in_ready   = !w_fifo_full && (r_state == ST_RUN) && !flush && !reset;
    assign w_push     = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_load     = !w_fifo_empty && (r_state == ST_RUN) && !flush
                        && (!r_out_valid || out_ready);

    assign w_head_pc    = w_fifo_rdata[ENTRY_W-1:INSTR_W];
    assign w_head_instr = w_fifo_rdata[INSTR_W-1:0];
    assign w_head_dec   = decode_instr(w_head_instr);

    decode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_wdata ({in_pc, in_instr}),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_next;
    end

    // FSM next state: halt once a HALT bundle is issued, resume releases, flush wins
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_load && (w_head_dec.cls == CLS_HALT)) w_state_next = ST_HALT;
            ST_HALT: if (resume) w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
        if (flush) w_state_next = ST_RUN;
    end

    // Output bundle register: load from FIFO head, drop valid on handshake
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_class   <= '0;
            r_out_alu_op  <= '0;
            r_out_opa     <= '0;
            r_out_opb     <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= w_head_pc;
            r_out_class   <= w_head_dec.cls;
            r_out_alu_op  <= w_head_dec.alu_op;
            r_out_opa     <= w_head_dec.opa;
            r_out_opb     <= w_head_dec.opb;
            r_out_illegal <= w_head_dec.illegal;
        end else if (w_out_fire) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_class   = r_out_class;
    assign out_alu_op  = r_out_alu_op;
    assign out_opa     = r_out_opa;
    assign out_opb     = r_out_opb;
    assign out_illegal = r_out_illegal;
    assign halted      = (r_state == ST_HALT);

`ifdef DECODE_STATS_EN
    logic [15:0] r_stat_decoded;
    logic [15:0] r_stat_illegal;

    // Saturating handshake counters; only reset clears them, flush does not
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (w_out_fire) begin
            if (r_stat_decoded != 16'hFFFF) r_stat_decoded <= r_stat_decoded + 16'd1;
            if (r_out_illegal && (r_stat_illegal != 16'hFFFF))
                r_stat_illegal <= r_stat_illegal + 16'd1;
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Scoreboard bench for instr_decode_stage: directed scenarios
//                followed by randomized traffic, checked against a
//                behavioural decode model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    localparam int FIFO_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [40:0] in_instr;
    logic [16:0] in_pc;
    logic        flush;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_pc;
    logic [2:0]  out_class;
    logic [5:0]  out_alu_op;
    logic [15:0] out_opa;
    logic [15:0] out_opb;
    logic        out_illegal;
    logic        halted;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_decoded;
    logic [15:0] stat_illegal;
`endif

    instr_decode_stage #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .resume      (resume),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_class   (out_class),
        .out_alu_op  (out_alu_op),
        .out_opa     (out_opa),
        .out_opb     (out_opb),
        .out_illegal (out_illegal),
        .halted      (halted)
`ifdef DECODE_STATS_EN
        ,
        .stat_decoded (stat_decoded),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected bundle, derived from the instruction-set rules
    typedef struct {
        logic [16:0] pc;
        logic [2:0]  cls;
        logic [5:0]  alu;
        logic [15:0] opa;
        logic [15:0] opb;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic [40:0] instr, input logic [16:0] pc);
        exp_t e;
        int   opc;
        opc   = int'(instr[8:0]);
        e.pc  = pc;
        e.alu = 6'd0;
        e.opa = instr[24:9];
        e.opb = instr[40:25];
        e.ill = 1'b0;
        if (opc == 0)                   e.cls = 3'd0;
        else if (opc < 64) begin        e.cls = 3'd1; e.alu = 6'(opc); end
        else if (opc == 64)             e.cls = 3'd2;
        else if (opc == 65)             e.cls = 3'd3;
        else if (opc == 128)            e.cls = 3'd4;
        else if (opc == 129)            e.cls = 3'd5;
        else if (opc == 511)            e.cls = 3'd6;
        else begin
            e.cls = 3'd7; e.ill = 1'b1; e.opa = 16'd0; e.opb = 16'd0;
        end
        return e;
    endfunction

    // Monitor: at each falling edge, account for the handshakes the next rising edge performs
    logic        prev_stall = 1'b0;
    logic [58:0] prev_b;
    int          m_dec = 0;
    int          m_ill = 0;

    always @(negedge clock) begin
        exp_t        e;
        logic [58:0] cur;
        cur = {out_pc, out_class, out_alu_op, out_opa, out_opb, out_illegal};
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
            m_dec = 0;
            m_ill = 0;
        end else begin
`ifdef DECODE_STATS_EN
            check("stat_decoded", stat_decoded, 64'(m_dec));
            check("stat_illegal", stat_illegal, 64'(m_ill));
`endif
            if (prev_stall) begin
                check("hold_valid",  out_valid, 1);
                check("hold_bundle", cur, prev_b);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got pc 0x%0h required no output at %0t", out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bundle", cur, {e.pc, e.cls, e.alu, e.opa, e.opb, e.ill});
                    if (e.ill && m_ill < 65535) m_ill++;
                end
                if (m_dec < 65535) m_dec++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
            if (flush) exp_q.delete();
            prev_stall = out_valid && !out_ready && !flush;
            prev_b     = cur;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] opc, input logic [16:0] pc);
        in_valid = v;
        in_instr = {16'($urandom), 16'($urandom), opc};
        in_pc    = pc;
    endtask

    function automatic logic [8:0] rand_opc();
        int sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       return 9'h000;
            1, 2, 3, 4, 5, 6: return 9'($urandom_range(1, 63));
            7:       return 9'h040;
            8:       return 9'h041;
            9:       return 9'h080;
            10:      return 9'h081;
            11:      return 9'h1FF;
            default: return 9'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; resume = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted",    halted, 0);
        check("rst_data", {out_pc, out_class, out_alu_op, out_opa, out_opb, out_illegal}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Streaming ALU 0x008: one-cycle latency then one bundle per cycle
        out_ready = 1'b1;
        drive(1'b1, 9'h008, 17'd0);
        tick();
        check("lat_first_valid", out_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) drive(1'b1, 9'h008, 17'(i));
            else       in_valid = 1'b0;
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_pc",    out_pc, 64'(i - 1));
            check("stream_class", out_class, 1);
            check("stream_aluop", out_alu_op, 8);
            check("stream_in_ready", in_ready, 1);
        end
        tick();
        check("stream_idle", out_valid, 0);

        // Backpressure: FIFO fills, in_ready drops, outputs hold, drain in order
        out_ready = 1'b0;
        drive(1'b1, 9'h001, 17'd10); tick();
        drive(1'b1, 9'h002, 17'd11); tick();
        drive(1'b1, 9'h003, 17'd12); tick();
        check("bp_in_ready", in_ready, 0);
        check("bp_valid",    out_valid, 1);
        check("bp_pc",       out_pc, 10);
        drive(1'b1, 9'h004, 17'd13);
        repeat (3) begin
            tick();
            check("bp_hold_pc", out_pc, 10);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(); check("bp_drain_pc1", out_pc, 11);
        tick(); check("bp_drain_pc2", out_pc, 12);
        tick(); check("bp_drain_idle", out_valid, 0);

        // HALT then ALU 0x001: halted, 0x001 retained until resume
        out_ready = 1'b0;
        drive(1'b1, 9'h1FF, 17'd20); tick();
        drive(1'b1, 9'h001, 17'd21); tick();
        in_valid = 1'b0;
        check("halt_halted",   halted, 1);
        check("halt_class",    out_class, 6);
        check("halt_pc",       out_pc, 20);
        check("halt_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("halt_bundle_out", out_valid, 0);
        check("halt_still",      halted, 1);
        tick();
        check("halt_no_pop", out_valid, 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_halted", halted, 0);
        tick();
        check("resume_valid", out_valid, 1);
        check("resume_pc",    out_pc, 21);
        check("resume_class", out_class, 1);
        tick();

        // Illegal opcode 0x0F0
        in_valid = 1'b1; in_instr = {16'hABCD, 16'h1234, 9'h0F0}; in_pc = 17'd30;
        tick();
        in_valid = 1'b0;
        tick();
        check("ill_class",   out_class, 7);
        check("ill_flag",    out_illegal, 1);
        check("ill_opa_opb", {out_opa, out_opb}, 0);
        tick();
`ifdef DECODE_STATS_EN
        check("ill_stat", stat_illegal, 1);
`endif

        // Flush with FIFO full and output valid
        out_ready = 1'b0;
        drive(1'b1, 9'h005, 17'd40); tick();
        drive(1'b1, 9'h006, 17'd41); tick();
        drive(1'b1, 9'h007, 17'd42); tick();
        drive(1'b1, 9'h009, 17'd43);
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid",    out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("flush_no_emit", out_valid, 0);
        end

        // Reset during HALT with work buffered
        out_ready = 1'b0;
        drive(1'b1, 9'h1FF, 17'd50); tick();
        drive(1'b1, 9'h011, 17'd51); tick();
        in_valid = 1'b0;
        check("rh_halted", halted, 1);
        reset = 1'b1;
        tick();
        check("rh_out_valid", out_valid, 0);
        check("rh_halted0",   halted, 0);
        check("rh_data", {out_pc, out_class, out_alu_op, out_opa, out_opb, out_illegal}, 0);
`ifdef DECODE_STATS_EN
        check("rh_stats", {stat_decoded, stat_illegal}, 0);
`endif
        reset = 1'b0;
        #1;
        check("rh_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("rh_no_emit", out_valid, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 3) != 0), rand_opc(), 17'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            resume    = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 799) == 0);
            tick();
        end

        // Drain everything still in flight
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            resume = halted;
            tick();
            if (exp_q.size() == 0 && !out_valid && !halted) break;
        end
        check("drain_remaining", 64'(exp_q.size()), 0);
        check("drain_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, input buffer entries (power of two, >=2).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  fetch offers instruction.
REQ-005 SHALL have port in_ready  out  1  stage accepts instruction.
REQ-006 SHALL have port in_instr  in  41  fetched instruction word.
REQ-007 SHALL have port in_pc  in  17  address of in_instr.
REQ-008 SHALL have port flush  in  1  discard all buffered/decoded work.
REQ-009 SHALL have port resume  in  1  leave HALT state.
REQ-010 SHALL have port out_valid  out  1  decoded bundle valid.
REQ-011 SHALL have port out_ready  in  1  execute consumes bundle.
REQ-012 SHALL have port out_pc  out  17  address of decoded instruction.
REQ-013 SHALL have port out_class  out  3  instruction class code.
REQ-014 SHALL have port out_alu_op  out  6  ALU operation select.
REQ-015 SHALL have port out_opa / out_opb  out  16 each  operand fields.
REQ-016 SHALL have port out_illegal  out  1  undefined opcode flag.
REQ-017 SHALL have port halted  out  1  FSM in HALT.

Function
REQ-018 Field map SHALL be: opcode = in_instr[8:0], opa = [24:9], opb = [40:25].
REQ-019 Classes SHALL be: 0x000 NOP=0; 0x001-0x03F ALU=1, alu_op=opcode[5:0]; 0x040 LOAD=2; 0x041 STORE=3; 0x080 JUMP=4; 0x081 BRZ=5; 0x1FF HALT=6; all others ILLEGAL=7.
REQ-020 Non-ALU classes SHALL drive alu_op 0; ILLEGAL SHALL drive out_illegal=1, opa=opb=0.
REQ-021 Input accept SHALL occur when in_valid && in_ready; entry pushed into FIFO at that edge.
REQ-022 in_ready SHALL be !fifo_full && state==RUN && !flush; no combinational path from out_ready.
REQ-023 Output register SHALL load FIFO head when FIFO non-empty, state==RUN, and (!out_valid || out_ready).
REQ-024 Minimum latency SHALL be: accepted at edge N, out_valid high after edge N+1.
REQ-025 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-026 FSM states SHALL be RUN, HALT; RUN->HALT at the edge a HALT-class bundle is loaded into the output register.
REQ-027 In HALT: no accept, no FIFO pop; buffered entries retained; HALT bundle still handshakes out normally.
REQ-028 HALT->RUN SHALL occur at edge where resume=1; resume in RUN is ignored.
REQ-029 flush SHALL, at next edge, empty FIFO, clear out_valid, force RUN; a simultaneous accept or load is discarded.
REQ-030 flush and resume together SHALL behave as flush.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push/pop SHALL keep occupancy constant.

Reset
REQ-032 reset SHALL, at the edge, set FIFO empty, state RUN, out_valid=0, halted=0, in_ready=0 during reset, all data outputs 0.
REQ-033 reset mid-operation SHALL discard all in-flight instructions; in_ready=1 first cycle after reset deasserts.

Configuration
REQ-034 Macro DECODE_STATS_EN, when defined, SHALL add ports stat_decoded out 16 and stat_illegal out 16.
REQ-035 stat_decoded SHALL increment per output handshake; stat_illegal per handshake with out_illegal; both saturate at 0xFFFF, clear on reset, unaffected by flush.
REQ-036 Without DECODE_STATS_EN ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-037 Package decode_pkg SHALL hold INSTR_W=41, PC_W=17, field bit positions, opcode constants, class enum, FSM state enum.
REQ-038 FIFO SHALL be sub-module decode_fifo (FIFO_DEPTH x 58 bits: pc+instr); decode logic in top.

Verification
REQ-039 Stream ALU 0x008 at pc 0..3, out_ready=1 -> four bundles, class 1, alu_op 0x08, one per cycle after 1-cycle latency.
REQ-040 out_ready=0 with 3 pushes -> in_ready drops once FIFO full (2) + output held; outputs stable; release drains in order.
REQ-041 Opcode 0x1FF then 0x001 -> halted=1, 0x001 held in FIFO; resume -> 0x001 emitted with class 1.
REQ-042 Opcode 0x0F0 -> class 7, out_illegal=1, opa=opb=0; stat_illegal=1 with DECODE_STATS_EN.
REQ-043 flush with FIFO full and out_valid=1 -> next cycle out_valid=0, in_ready=1, prior entries never emitted.
REQ-044 reset asserted mid-stream during HALT -> all outputs 0, halted=0, counters 0 next cycle.
